// File: rtl/wb_ddr2_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_ddr2_port_arbiter: round-robin Wishbone B3 arbiter for the DDR2 slave.  |
// | Optional watchdog/FLUSH enabled by macro WB_ARB_TIMEOUT_EN.  Rev 1.0       |
// +----------------------------------------------------------------------------+
module wb_ddr2_port_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DW          = 64,
    parameter int AW          = 32,
    parameter int SW          = DW / 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst_n,
    input  logic [NUM_MASTERS-1:0]     m_cyc_i,
    input  logic [NUM_MASTERS-1:0]     m_stb_i,
    input  logic [NUM_MASTERS-1:0]     m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]  m_dat_i,
    input  logic [NUM_MASTERS*SW-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]   m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]   m_bte_i,
    output logic [NUM_MASTERS-1:0]     m_ack_o,
    output logic [NUM_MASTERS-1:0]     m_err_o,
    output logic [NUM_MASTERS-1:0]     m_rty_o,
    output logic [DW-1:0]              m_dat_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [AW-1:0]              s_adr_o,
    output logic [DW-1:0]              s_dat_o,
    output logic [SW-1:0]              s_sel_o,
    output logic [2:0]                 s_cti_o,
    output logic [1:0]                 s_bte_o,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    input  logic                       s_rty_i,
    input  logic [DW-1:0]              s_dat_i,
    output logic [NUM_MASTERS-1:0]     grant_o,
    output logic                       busy_o
);

    localparam int c_iw = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] c_one = NUM_MASTERS'(1);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_FLUSH = 2'd2} state_t;
    localparam int c_cw = $clog2(TIMEOUT) + 1;
    logic [c_cw-1:0] r_cnt;
    logic            w_resp;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_t;
`endif

    state_t                 r_state;
    logic [c_iw-1:0]        r_ptr;
    logic [c_iw-1:0]        r_gidx;
    logic [NUM_MASTERS-1:0] r_grant;
    logic                   r_busy;

    logic [c_iw-1:0]        w_cand [NUM_MASTERS];
    logic [AW-1:0]          w_adr  [NUM_MASTERS];
    logic [DW-1:0]          w_dat  [NUM_MASTERS];
    logic [SW-1:0]          w_sel  [NUM_MASTERS];
    logic [2:0]             w_cti  [NUM_MASTERS];
    logic [1:0]             w_bte  [NUM_MASTERS];
    logic [c_iw-1:0]        w_pick;
    logic                   w_any;
    logic                   w_in_grant;
    logic                   w_gcyc;
    logic [c_iw-1:0]        w_sidx;
    logic                   w_timeout;

    // Candidate k is (ptr + k) mod N; ptr and k are both < N so one subtraction suffices.
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_cand
        logic [c_iw:0] w_sum;
        assign w_sum     = {1'b0, r_ptr} + (c_iw+1)'(k);
        assign w_cand[k] = (w_sum >= (c_iw+1)'(NUM_MASTERS)) ?
                           c_iw'(w_sum - (c_iw+1)'(NUM_MASTERS)) : w_sum[c_iw-1:0];
        assign w_adr[k]  = m_adr_i[k*AW +: AW];
        assign w_dat[k]  = m_dat_i[k*DW +: DW];
        assign w_sel[k]  = m_sel_i[k*SW +: SW];
        assign w_cti[k]  = m_cti_i[k*3 +: 3];
        assign w_bte[k]  = m_bte_i[k*2 +: 2];
    end

    // Scan from the far end so the candidate closest to ptr wins.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (m_cyc_i[w_cand[k]]) begin
                w_pick = w_cand[k];
                w_any  = 1'b1;
            end
        end
    end

    assign w_in_grant = (r_state == ST_GRANT);
    assign w_gcyc     = m_cyc_i[r_gidx];
    assign w_sidx     = w_in_grant ? r_gidx : '0;

    assign s_cyc_o = w_in_grant & m_cyc_i[r_gidx];
    assign s_stb_o = w_in_grant & m_stb_i[r_gidx];
    assign s_we_o  = wb_rst_n & m_we_i[w_sidx];
    assign s_adr_o = {AW{wb_rst_n}} & w_adr[w_sidx];
    assign s_dat_o = {DW{wb_rst_n}} & w_dat[w_sidx];
    assign s_sel_o = {SW{wb_rst_n}} & w_sel[w_sidx];
    assign s_cti_o = {3{wb_rst_n}}  & w_cti[w_sidx];
    assign s_bte_o = {2{wb_rst_n}}  & w_bte[w_sidx];

`ifdef WB_ARB_TIMEOUT_EN
    assign w_resp    = s_ack_i | s_err_i | s_rty_i;
    assign w_timeout = s_stb_o & ~w_resp & (r_cnt == c_cw'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Responses reach only the owner, and only while it is strobing.
    assign m_ack_o = r_grant & {NUM_MASTERS{s_ack_i & s_stb_o}};
    assign m_err_o = r_grant & {NUM_MASTERS{(s_err_i & s_stb_o) | w_timeout}};
    assign m_rty_o = r_grant & {NUM_MASTERS{s_rty_i & s_stb_o}};
    assign m_dat_o = {DW{wb_rst_n}} & s_dat_i;

    assign grant_o = r_grant;
    assign busy_o  = r_busy;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gidx  <= w_pick;
                        r_grant <= c_one << w_pick;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!w_gcyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= (r_gidx == c_iw'(NUM_MASTERS - 1)) ? '0 : r_gidx + 1'b1;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= ST_FLUSH;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ST_FLUSH: begin
                    if (!w_gcyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= (r_gidx == c_iw'(NUM_MASTERS - 1)) ? '0 : r_gidx + 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            if (w_in_grant && s_stb_o && !w_resp) r_cnt <= r_cnt + 1'b1;
            else                                  r_cnt <= '0;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ddr2_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_ddr2_port_arbiter: directed self-checking bench, 4 masters.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_wb_ddr2_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [N-1:0]    m_ack, m_err, m_rty;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic            s_ack, s_err, s_rty;
    logic [DW-1:0]   s_dat;
    logic [N-1:0]    grant;
    logic            busy;

    int tests = 0;
    int fails = 0;

    wb_ddr2_port_arbiter #(
        .NUM_MASTERS(N), .DW(DW), .AW(AW), .SW(SW), .TIMEOUT(16)
    ) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_cti_o(s_cti), .s_bte_o(s_bte),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        m_sel = '0; m_cti = '0; m_bte = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        s_dat = 64'hDEAD_BEEF_0123_4567;
        m_adr[0 +: AW] = 32'h55;
        #3;
        chk("rst_grant", grant, 0);
        chk("rst_scyc", s_cyc, 0);
        chk("rst_mdat", m_dat_o, 0);
        chk("rst_sadr", s_adr, 0);
        tick(); tick();
        rst_n = 1'b1;

        // idle: stray slave ack must not leak out
        s_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_grant", grant, 0);
            chk("idle_scyc", s_cyc, 0);
            chk("idle_ack", m_ack, 0);
        end
        chk("idle_sadr_m0", s_adr, 32'h55);
        chk("idle_mdat", m_dat_o, 64'hDEAD_BEEF_0123_4567);
        s_ack = 1'b0;

        // simultaneous m0/m1, ptr=0
        m_cyc = 4'b0011; m_stb = 4'b0011;
        m_adr[0 +: AW] = 32'h100; m_adr[AW +: AW] = 32'h200;
        #1 chk("arb_latency_scyc", s_cyc, 0);
        tick();
        chk("t2_grant_m0", grant, 4'b0001);
        chk("t2_scyc", s_cyc, 1);
        chk("t2_sadr", s_adr, 32'h100);
        chk("t2_busy", busy, 1);
        s_ack = 1'b1;
        #1 chk("t2_ack_m0", m_ack, 4'b0001);
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1 chk("t2_drop_scyc", s_cyc, 0);
        tick();
        chk("t2_gap_grant", grant, 0);
        chk("t2_gap_scyc", s_cyc, 0);
        chk("t2_gap_busy", busy, 0);
        tick();
        chk("t2_grant_m1", grant, 4'b0010);
        chk("t2_sadr_m1", s_adr, 32'h200);

        // ack while stb low is dropped
        m_stb[1] = 1'b0; s_ack = 1'b1;
        #1 chk("ack_no_stb", m_ack, 0);

        // m1 8-beat incrementing burst, m0 requests at beat 3
        for (int i = 0; i < 8; i++) begin
            m_stb[1] = 1'b1;
            m_adr[AW +: AW] = 32'h1000 + 32'(8 * i);
            m_cti[3 +: 3] = (i == 7) ? 3'b111 : 3'b010;
            s_ack = 1'b1;
            s_dat = 64'hA000 + 64'(i);
            if (i == 3) begin m_cyc[0] = 1'b1; m_stb[0] = 1'b1; end
            #1;
            chk("burst_ack", m_ack, 4'b0010);
            chk("burst_adr", s_adr, 32'h1000 + 32'(8 * i));
            chk("burst_cti", s_cti, (i == 7) ? 3'b111 : 3'b010);
            chk("burst_grant", grant, 4'b0010);
            chk("burst_mdat", m_dat_o, 64'hA000 + 64'(i));
            tick();
        end
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        chk("t3_gap_grant", grant, 0);
        tick();
        chk("t3_grant_m0", grant, 4'b0001);
        chk("t3_sadr_m0", s_adr, 32'h100);

        // async reset mid-burst
        m_cti[0 +: 3] = 3'b010; s_ack = 1'b1;
        #1 chk("pre_rst_ack", m_ack, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_scyc", s_cyc, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_ack", m_ack, 0);
        chk("mid_rst_busy", busy, 0);
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        tick();
        rst_n = 1'b1;

        // all four request continuously; each drops for one cycle after its grant
        m_cyc = 4'b1111; m_stb = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("rr_grant", grant, 4'b0001 << (j % 4));
            m_cyc[j % 4] = 1'b0; m_stb[j % 4] = 1'b0;
            tick();
            chk("rr_gap_grant", grant, 0);
            chk("rr_gap_scyc", s_cyc, 0);
            m_cyc[j % 4] = 1'b1; m_stb[j % 4] = 1'b1;
        end
        m_cyc = '0; m_stb = '0;
        tick(); tick();

        // hung slave on m2 (ptr=1 -> only m2 requesting)
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        tick();
        chk("hung_grant", grant, 4'b0100);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 0; c < 15; c++) begin
            chk("wd_quiet", m_err, 0);
            tick();
        end
        chk("wd_fire", m_err, 4'b0100);
        tick();
        chk("flush_err_once", m_err, 0);
        chk("flush_scyc", s_cyc, 0);
        chk("flush_busy", busy, 1);
        s_ack = 1'b1;
        #1 chk("flush_ack_dropped", m_ack, 0);
        s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        tick();
        chk("flush_exit_busy", busy, 0);
        chk("flush_exit_grant", grant, 0);
`else
        for (int c = 0; c < 40; c++) begin
            chk("hung_no_err", m_err, 0);
            chk("hung_hold", grant, 4'b0100);
            tick();
        end
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        tick();
        chk("hung_release", grant, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
